// File: rtl/uart_poll_master_if.sv
// rtl/uart_poll_master_if.sv - bus between the poll/echo master and the UART register block
interface uart_poll_master_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_poll_master.sv
// rtl/uart_poll_master.sv - polls a UART, echoes received bytes back through a 4-entry FIFO
module uart_poll_master #(
   parameter logic [31:0] UART_BASE   = 32'h40000018,
   parameter int unsigned HOLD_CYCLES = 3
) (
   input  logic                CLK,
   input  logic                Reset_n,
   input  logic                enable,
   uart_poll_master_if.master  bus,
   output logic [7:0]          rx_byte,
   output logic                rx_valid,
   output logic [2:0]          fifo_count,
   output logic                overflow
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CFG  = 3'd1;
   localparam logic [2:0] POLL = 3'd2;
   localparam logic [2:0] RDRX = 3'd3;
   localparam logic [2:0] WRTX = 3'd4;
   localparam logic [2:0] HOLD = 3'd5;

   localparam logic [31:0] ADDR_TXD = UART_BASE;
   localparam logic [31:0] ADDR_RXD = UART_BASE + 32'd4;
   localparam logic [31:0] ADDR_CON = UART_BASE + 32'd8;

   localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [HW-1:0] hold_cnt;
   logic [7:0]    fifo_mem [4];
   logic [1:0]    wr_ptr;
   logic [1:0]    rd_ptr;
   logic          push;

   logic unused_rdata;
   assign unused_rdata = ^{bus.rdata[31:8], bus.rdata[2:0]};

   assign push = (state == RDRX) && (fifo_count < 3'd4);

   // RX is checked before TX so an incoming byte is never left waiting behind an echo
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (enable) state_nxt = CFG;
         CFG:  state_nxt = POLL;
         POLL: begin
            if (!enable)                                       state_nxt = IDLE;
            else if (bus.rdata[3])                             state_nxt = RDRX;
            else if (!bus.rdata[4] && (fifo_count != 3'd0))    state_nxt = WRTX;
            else                                               state_nxt = POLL;
         end
         RDRX: state_nxt = POLL;
         WRTX: state_nxt = (HOLD_CYCLES == 0) ? POLL : HOLD;
         HOLD: if (hold_cnt == HOLD_LAST) state_nxt = POLL;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus strobes come from registered state only, so rdata never loops back onto them
   always_comb begin
      bus.rd    = 1'b0;
      bus.wr    = 1'b0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
      case (state)
         CFG: begin
            bus.wr    = 1'b1;
            bus.addr  = ADDR_CON;
            bus.wdata = 32'h3;
         end
         POLL: begin
            bus.rd   = 1'b1;
            bus.addr = ADDR_CON;
         end
         RDRX: begin
            bus.rd   = 1'b1;
            bus.addr = ADDR_RXD;
         end
         WRTX: begin
            bus.wr    = 1'b1;
            bus.addr  = ADDR_TXD;
            bus.wdata = {24'h0, fifo_mem[rd_ptr]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         rx_byte    <= 8'h0;
         rx_valid   <= 1'b0;
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
         overflow   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rx_valid <= (state == RDRX);
         hold_cnt <= ((state == HOLD) && (hold_cnt != HOLD_LAST)) ? hold_cnt + HW'(1) : '0;

         if (state == CFG)
            overflow <= 1'b0;

         if (state == RDRX) begin
            rx_byte <= bus.rdata[7:0];
            if (push) begin
               wr_ptr     <= wr_ptr + 2'd1;
               fifo_count <= fifo_count + 3'd1;
            end else begin
               overflow <= 1'b1;
            end
         end

         if (state == WRTX) begin
            rd_ptr     <= rd_ptr + 2'd1;
            fifo_count <= fifo_count - 3'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         fifo_mem[wr_ptr] <= bus.rdata[7:0];
   end

endmodule

// File: tb/tb_uart_poll_master.sv
// tb/tb_uart_poll_master.sv - directed and randomized bench with a transaction-level echo model
module tb_uart_poll_master;
   localparam logic [31:0] BASE = 32'h40000018;
   localparam int          HOLD = 3;
   localparam int K_IDLE = 0, K_CFG = 1, K_CON = 2, K_RXD = 3, K_TXD = 4, K_BAD = 7;

   logic       CLK = 1'b0;
   logic       Reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [2:0] fifo_count;
   logic       overflow;

   uart_poll_master_if bus();

   uart_poll_master #(.UART_BASE(BASE), .HOLD_CYCLES(HOLD)) dut (
      .CLK        (CLK),
      .Reset_n    (Reset_n),
      .enable     (enable),
      .bus        (bus),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 CLK = ~CLK;

   // peripheral: pending RX bytes, a TX busy flag, and junk on the unused data bits
   logic [7:0]  rxq[$];
   logic        p_busy = 1'b0;
   logic        p_rx = 1'b0;
   logic [7:0]  p_rxd = 8'h0;
   logic [31:0] junk = 32'h0;

   always_comb begin
      bus.rdata = junk;
      if (bus.rd && bus.addr == BASE + 32'd8)
         bus.rdata = {junk[31:5], p_busy, p_rx, junk[2:0]};
      else if (bus.rd && bus.addr == BASE + 32'd4)
         bus.rdata = {junk[31:8], p_rxd};
   end

   // reference model state
   int unsigned passes = 0, total = 0, fails = 0;
   logic [7:0]  mq[$];
   logic [7:0]  tx_log[$];
   logic [7:0]  acc_log[$];
   logic [7:0]  eq[$];
   logic        m_ovf;
   int          prev_kind;
   logic        prev_en, prev_rx, prev_busy;
   int          hold_left;
   logic        force_con;
   logic        exp_valid;
   logic [7:0]  exp_byte;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      p_rx  = (rxq.size() > 0);
      p_rxd = p_rx ? rxq[0] : junk[7:0];
   endtask

   task automatic add_rx(input logic [7:0] b);
      rxq.push_back(b);
      refresh();
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf     = 1'b0;
      prev_kind = K_IDLE;
      prev_en   = 1'b0;
      prev_rx   = 1'b0;
      prev_busy = 1'b0;
      hold_left = 0;
      force_con = 1'b0;
      exp_valid = 1'b0;
      exp_byte  = 8'h0;
   endtask

   function automatic int classify();
      if (!bus.rd && !bus.wr) return (bus.addr == 32'h0 && bus.wdata == 32'h0) ? K_IDLE : K_BAD;
      if (bus.rd && bus.wr) return K_BAD;
      if (bus.rd && bus.wdata != 32'h0) return K_BAD;
      if (bus.rd && bus.addr == BASE + 32'd8) return K_CON;
      if (bus.rd && bus.addr == BASE + 32'd4) return K_RXD;
      if (bus.wr && bus.addr == BASE + 32'd8 && bus.wdata == 32'h3) return K_CFG;
      if (bus.wr && bus.addr == BASE && bus.wdata[31:8] == 24'h0) return K_TXD;
      return K_BAD;
   endfunction

   // one bus cycle: predict the access from the previous one, compare, update the model
   task automatic step();
      int         exp_kind;
      int         k;
      logic       did_rxd;
      logic [7:0] b;
      if (hold_left > 0) begin
         exp_kind = K_IDLE;
         hold_left--;
         if (hold_left == 0) force_con = 1'b1;
      end else if (force_con) begin
         exp_kind  = K_CON;
         force_con = 1'b0;
      end else begin
         case (prev_kind)
            K_IDLE:        exp_kind = prev_en ? K_CFG : K_IDLE;
            K_CFG, K_RXD:  exp_kind = K_CON;
            K_CON:         exp_kind = !prev_en ? K_IDLE : prev_rx ? K_RXD :
                                      (!prev_busy && mq.size() > 0) ? K_TXD : K_CON;
            default:       exp_kind = K_CON;
         endcase
      end
      k = classify();
      check("bus_kind", 32'(k), 32'(exp_kind));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("rx_valid", 32'(rx_valid), 32'(exp_valid));
      if (exp_valid) check("rx_byte", 32'(rx_byte), 32'(exp_byte));
      exp_valid = 1'b0;
      did_rxd   = 1'b0;
      case (k)
         K_CFG: m_ovf = 1'b0;
         K_RXD: begin
            b         = p_rxd;
            exp_byte  = b;
            exp_valid = 1'b1;
            did_rxd   = 1'b1;
            if (mq.size() < 4) begin
               mq.push_back(b);
               acc_log.push_back(b);
            end else begin
               m_ovf = 1'b1;
            end
         end
         K_TXD: begin
            tx_log.push_back(bus.wdata[7:0]);
            if (mq.size() > 0) check("tx_data", 32'(bus.wdata[7:0]), 32'(mq.pop_front()));
            hold_left = HOLD;
         end
         default: ;
      endcase
      prev_kind = k;
      prev_en   = enable;
      prev_rx   = p_rx;
      prev_busy = p_busy;
      @(posedge CLK);
      #1;
      if (did_rxd && rxq.size() > 0) void'(rxq.pop_front());
      junk = $urandom;
      refresh();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] e[$]);
      check({tag, "_count"}, 32'(tx_log.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < tx_log.size(); i++)
         check(tag, 32'(tx_log[i]), 32'(e[i]));
      tx_log.delete();
   endtask

   task automatic wait_txd(input string tag);
      int n;
      n = 0;
      while (classify() != K_TXD && n < 20) begin
         step();
         n++;
      end
      check(tag, 32'(classify()), 32'(K_TXD));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd"}, 32'(bus.rd), 32'h0);
      check({tag, "_wr"}, 32'(bus.wr), 32'h0);
      check({tag, "_addr"}, bus.addr, 32'h0);
      check({tag, "_wdata"}, bus.wdata, 32'h0);
      check({tag, "_rx_byte"}, 32'(rx_byte), 32'h0);
      check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
      check({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
      check({tag, "_overflow"}, 32'(overflow), 32'h0);
   endtask

   initial begin
      logic [7:0] b1, b2, b3;
      int         n;
      refresh();
      model_reset();

      // reset with enable high, then the single CFG write and continuous polling
      enable  = 1'b1;
      Reset_n = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_all_zero("reset");
      Reset_n = 1'b1;
      step();
      check("cfg_wr", 32'(bus.wr), 32'h1);
      check("cfg_addr", bus.addr, 32'h40000020);
      check("cfg_wdata", bus.wdata, 32'h3);
      run(6);

      // single byte echo
      p_busy = 1'b0;
      add_rx(8'hA5);
      step();
      check("rxd_addr", bus.addr, 32'h4000001C);
      run(12);
      eq = {8'hA5};
      expect_tx("echo_a5", eq);

      // TX busy holds two queued bytes back
      p_busy = 1'b1;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      add_rx(b1);
      add_rx(b2);
      run(30);
      check("busy_no_tx", 32'(tx_log.size()), 32'h0);
      check("busy_count", 32'(fifo_count), 32'd2);
      p_busy = 1'b0;
      run(20);
      eq = {b1, b2};
      expect_tx("busy_order", eq);

      // five bytes into a four-entry FIFO
      p_busy = 1'b1;
      for (int i = 1; i <= 5; i++) add_rx(8'(i));
      run(40);
      check("sat_count", 32'(fifo_count), 32'd4);
      check("sat_overflow", 32'(overflow), 32'h1);
      check("sat_rx_byte", 32'(rx_byte), 32'h05);
      p_busy = 1'b0;
      run(40);
      eq = {8'h01, 8'h02, 8'h03, 8'h04};
      expect_tx("sat_tx", eq);

      // RX and TX both possible in one poll: RX goes first
      p_busy = 1'b1;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      add_rx(b1);
      run(10);
      p_busy = 1'b0;
      add_rx(b2);
      n = 0;
      while (classify() == K_CON && n < 10) begin
         step();
         n++;
      end
      check("rx_first", 32'(classify()), 32'(K_RXD));
      run(20);
      eq = {b1, b2};
      expect_tx("prio_tx", eq);

      // enable dropped during HOLD: hold completes, one poll, idle, FIFO kept
      p_busy = 1'b1;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      add_rx(b1);
      add_rx(b2);
      run(10);
      p_busy = 1'b0;
      wait_txd("hold_txd_seen");
      step();
      enable = 1'b0;
      run(10);
      check("idle_keep_count", 32'(fifo_count), 32'd1);
      check("idle_no_rd", 32'(bus.rd), 32'h0);
      enable = 1'b1;
      run(15);
      eq = {b1, b2};
      expect_tx("reenable_tx", eq);

      // reset pulsed during WRTX
      p_busy = 1'b1;
      add_rx(8'($urandom));
      add_rx(8'($urandom));
      run(10);
      p_busy = 1'b0;
      wait_txd("wrtx_seen");
      #2;
      Reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(posedge CLK);
      #1;
      rxq.delete();
      refresh();
      model_reset();
      tx_log.delete();
      Reset_n = 1'b1;
      run(10);

      // randomized traffic against the model
      acc_log.delete();
      tx_log.delete();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) add_rx(8'($urandom));
         if ($urandom_range(0, 7) == 0) p_busy = ~p_busy;
         if ($urandom_range(0, 40) == 0) enable = ~enable;
         step();
      end
      enable = 1'b1;
      p_busy = 1'b0;
      n = 0;
      while ((rxq.size() > 0 || mq.size() > 0) && n < 400) begin
         step();
         n++;
      end
      run(8);
      check("drain_done", 32'(rxq.size() + mq.size()), 32'h0);
      eq = acc_log;
      expect_tx("random_tx", eq);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/uart_poll_master.md
UART_POLL_MASTER -- requirements
Module: uart_poll_master

Interface
REQ-001 Parameter: UART_BASE, default 32'h40000018, address of the TXD register; RXD is at UART_BASE+4 and CON at UART_BASE+8.
REQ-002 Parameter: HOLD_CYCLES, default 3, number of idle bus cycles after every TXD write.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = run the poll/forward loop, 0 = return to idle.
REQ-006 rd  output  1  bus read strobe to the UART peripheral.
REQ-007 wr  output  1  bus write strobe to the UART peripheral.
REQ-008 addr  output  32  bus address; 32'h0 when rd=wr=0.
REQ-009 wdata  output  32  bus write data; 32'h0 when wr=0.
REQ-010 rdata  input  32  read data, valid combinationally in the same cycle as rd.
REQ-011 rx_byte  output  8  last byte read from RXD.
REQ-012 rx_valid  output  1  one-cycle pulse, rx_byte updated.
REQ-013 fifo_count  output  3  occupancy of the internal echo FIFO, 0..4.
REQ-014 overflow  output  1  sticky; an RX byte was dropped because the FIFO was full.

Function
REQ-015 rd, wr, addr and wdata shall be decoded from registered state only, with no combinational path from rdata or enable; rd and wr shall never both be 1.
REQ-016 States: IDLE, CFG, POLL, RDRX, WRTX, HOLD; exactly one bus access per cycle in CFG, POLL, RDRX and WRTX.
REQ-017 IDLE: rd=wr=0; enable=1 -> CFG on the next edge.
REQ-018 CFG: wr=1, addr=UART_BASE+8, wdata=32'h3 (both interrupt-flag enables on); overflow cleared; -> POLL.
REQ-019 POLL: rd=1, addr=UART_BASE+8; next state is decided on this edge from rdata[4:0], in this order: enable=0 -> IDLE; rdata[3]=1 -> RDRX; rdata[4]=0 and fifo_count>0 -> WRTX; otherwise -> POLL.
REQ-020 RX takes priority over TX when both are possible in the same POLL cycle.
REQ-021 RDRX: rd=1, addr=UART_BASE+4; rdata[7:0] is loaded into rx_byte, and rx_valid=1 in the following cycle.
REQ-022 In RDRX, the byte is pushed to the FIFO if fifo_count<4; otherwise it is dropped and overflow is set to 1. The next state is POLL.
REQ-023 WRTX: wr=1, addr=UART_BASE, wdata={24'h0, FIFO head}; the head is popped on this edge (fifo_count decrements); -> HOLD.
REQ-024 HOLD: rd=wr=0 for exactly HOLD_CYCLES cycles, so the peripheral busy bit CON[4] is valid before the next poll; -> POLL.
REQ-025 FIFO: 4 entries, 2-bit pointers that wrap modulo 4, first in first out. Push and pop never occur in the same cycle because they happen in different states.
REQ-026 enable is sampled only in IDLE and POLL; an access already started (RDRX, WRTX or HOLD sequence) always completes first.
REQ-027 Leaving POLL for IDLE shall not flush the FIFO; on re-enable, CFG runs again and queued bytes are then sent.

Reset
REQ-028 Reset_n=0 shall immediately force: state=IDLE, rd=wr=0, addr=wdata=0, rx_byte=0, rx_valid=0, fifo_count=0 (pointers 0), overflow=0, HOLD counter=0.
REQ-029 Reset asserted mid-access (RDRX, WRTX or HOLD) abandons the access; any byte in flight is lost.
REQ-030 After Reset_n rises, the first bus access shall be CFG, occurring one cycle after enable is seen high.

Verification
REQ-031 Reset with enable=1, then release -> one CFG write (addr 40000020, wdata 3), followed by continuous CON reads.
REQ-032 CON returns 5'b01000 with RXD=8'hA5 -> RXD read at 4000001C; next cycle rx_byte=A5, rx_valid=1, fifo_count=1; then CON=0 -> TXD write wdata=000000A5, fifo_count=0, then 3 idle cycles.
REQ-033 CON[4]=1 (TX busy) with 2 bytes queued -> no TXD write until CON[4]=0; the bytes are then written in arrival order, each followed by 3 idle cycles.
REQ-034 Five RX bytes 01..05 with CON[4] held at 1 -> fifo_count saturates at 4, overflow=1, byte 05 is visible on rx_byte but not queued; TX then sends 01,02,03,04.
REQ-035 CON=5'b01000 in the same poll that TX would be allowed, with 1 byte queued -> RDRX occurs before WRTX.
REQ-036 enable dropped during HOLD -> HOLD completes, then one POLL, then IDLE with the FIFO preserved; Reset_n pulsed during WRTX -> all outputs are 0 within the same cycle.
